ball_stepper: RTL and testbench
===============================

Name: ball_stepper

Overview:
- Upstream motion stage for the pixel-radius renderer: owns the ball centre (x1, y1) that the radius check compares each scanned pixel against.
- Advances the centre once every STEP_DIV frames and reflects it off the playfield walls.
- Flags each position update and each wall hit for downstream effects.
- Position is held stable between steps, so the combinational renderer sees a constant centre for a whole frame.

Parameters:
- X_MAX, 63: rightmost legal x (playfield x is 0..X_MAX).
- Y_MAX, 31: bottom legal y (playfield y is 0..Y_MAX).
- X_INIT, 32: serve/reset x.
- Y_INIT, 16: serve/reset y.
- STEP_DIV, 4: frame pulses per position step; must be >= 1.
- SPEED, 1: pixels moved per axis per step; must satisfy 1 <= SPEED <= min(X_MAX, Y_MAX).

Ports:
- clock  in  1  system clock, all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_pulse  in  1  single-cycle pulse, once per frame (from the edge detector on vsync).
- run  in  1  high = motion allowed; low = pause.
- launch  in  1  single-cycle serve request.
- x1  out  16  signed ball centre x.
- y1  out  16  signed ball centre y.
- dir_x  out  1  1 = +x, 0 = -x.
- dir_y  out  1  1 = +y, 0 = -y.
- pos_update  out  1  one-cycle pulse; x1/y1 took a new value this cycle.
- bounce  out  1  one-cycle pulse; a direction flipped at this step.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low on rst_n.
- Reset values (applied immediately on rst_n low):
  - x1=X_INIT, y1=Y_INIT, dir_x=1, dir_y=1.
  - pos_update=0, bounce=0.
  - state=IDLE, frame divider=0.
- States:
  - IDLE: no motion; frame_pulse ignored.
  - MOVING: frame_pulse increments the divider.
  - PAUSED: frame_pulse ignored; divider held.
- Transitions:
  - Any state + launch: x1/y1 to INIT, dirs to 1/1, divider to 0. Next state MOVING if run=1, else PAUSED.
  - MOVING + run=0 (no launch): PAUSED.
  - PAUSED + run=1 (no launch): MOVING.
  - IDLE is left only by launch.
- Priority: launch > run change > frame_pulse. A frame_pulse in the same cycle as launch is dropped (no step, no divider increment).
- Divider:
  - In MOVING, each frame_pulse increments it.
  - When the pre-increment value is STEP_DIV-1, it wraps to 0 and a step is performed in that same clock edge.
- Step arithmetic, per axis, done in 17-bit signed:
  - raw = pos + SPEED if dir=1, else pos - SPEED.
  - raw > MAX: pos = 2*MAX - raw, dir flips to 0.
  - raw < 0: pos = -raw, dir flips to 1.
  - Otherwise pos = raw.
  - Result is always within 0..MAX.
- Output timing:
  - New x1/y1/dir values are visible the cycle after the frame_pulse edge that triggers the step.
  - pos_update is high for exactly that one cycle.
  - bounce is high in the same cycle if either axis flipped. A corner hit (both axes flip) still gives a single one-cycle pulse.
- Launch does not assert pos_update or bounce.
- A frame_pulse while PAUSED or IDLE produces no pulses.

Optional Feature:
- Macro: BALL_WRAP_EN.
- Defined:
  - x axis wraps instead of reflecting: raw > X_MAX gives raw - (X_MAX+1); raw < 0 gives raw + (X_MAX+1).
  - dir_x never changes after launch.
  - y axis still reflects; bounce reports y flips only.
- Undefined: both axes reflect as above.

Test Plan:
- Async reset: launch, run 20 frame pulses, then drop rst_n between clock edges -> x1=32, y1=16, dir_x=dir_y=1 before the next posedge; the state stays IDLE and 8 further frame pulses cause no change.
- Divider: launch with run=1, then 3 frame pulses -> x1=32/y1=16 and no pos_update; 4th pulse -> next cycle x1=33, y1=17, pos_update high for exactly 1 cycle, bounce=0.
- Wall reflect: defaults, launch, 64 frame pulses (16 steps) -> after step 15 y1=31; after step 16 x1=48, y1=30, dir_y=0, bounce high for 1 cycle alongside pos_update.
- Corner: X_INIT=62, Y_INIT=30, STEP_DIV=1; launch, then pulse -> 63/31 with bounce=0; next pulse -> 62/30, dir_x=dir_y=0, a single bounce cycle.
- Pause/hold: STEP_DIV=4; launch, 2 pulses, run=0, 10 pulses (no change, no pulses), run=1, 2 pulses -> step to 33/17 on the 2nd post-resume pulse.
- Launch collision: mid-run, launch and frame_pulse asserted in the same cycle with divider=3 -> x1=32/y1=16, dirs=1/1, no pos_update; a step occurs only after 4 more pulses. With BALL_WRAP_EN, X_INIT=63, STEP_DIV=1: one pulse -> x1=0, dir_x=1, no bounce.

Source files
------------

// File: rtl/ball_stepper_if.sv
// ============================================================================
// Module      : ball_stepper_if
// Description : Control and result bundle between the frame controller
//               (master) and the ball_stepper motion stage (slave).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ball_stepper_if;
    logic               frame_pulse;
    logic               run;
    logic               launch;
    logic signed [15:0] x1;
    logic signed [15:0] y1;
    logic               dir_x;
    logic               dir_y;
    logic               pos_update;
    logic               bounce;

    modport master (
        output frame_pulse, run, launch,
        input  x1, y1, dir_x, dir_y, pos_update, bounce
    );

    modport slave (
        input  frame_pulse, run, launch,
        output x1, y1, dir_x, dir_y, pos_update, bounce
    );
endinterface

`default_nettype wire

// File: rtl/ball_stepper.sv
// ============================================================================
// Module      : ball_stepper
// Description : Ball-centre motion stage. Steps (x1, y1) once every STEP_DIV
//               frame pulses and reflects off the playfield walls. Defining
//               BALL_WRAP_EN makes the x axis wrap around instead of reflect.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ball_stepper #(
    parameter int X_MAX    = 63,
    parameter int Y_MAX    = 31,
    parameter int X_INIT   = 32,
    parameter int Y_INIT   = 16,
    parameter int STEP_DIV = 4,
    parameter int SPEED    = 1
) (
    input  wire logic     clock,
    input  wire logic     rst_n,
    ball_stepper_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam int                     DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic signed [16:0]     X_MAX_S  = 17'(X_MAX);
    localparam logic signed [16:0]     Y_MAX_S  = 17'(Y_MAX);
    localparam logic signed [16:0]     SPEED_S  = 17'(SPEED);
    localparam logic signed [15:0]     X_INIT_S = 16'(X_INIT);
    localparam logic signed [15:0]     Y_INIT_S = 16'(Y_INIT);

    // Returns {new_dir, new_pos}; arithmetic is 17-bit so the overshoot
    // past either wall never aliases before it is folded back.
    function automatic logic [16:0] reflect_axis(
        input logic signed [15:0] pos,
        input logic               dir,
        input logic signed [16:0] max_v
    );
        logic signed [16:0] pos_x;
        logic signed [16:0] raw;
        logic signed [16:0] res;
        logic               new_dir;
        pos_x = {pos[15], pos};
        raw   = dir ? (pos_x + SPEED_S) : (pos_x - SPEED_S);
        if (raw > max_v) begin
            res     = (max_v <<< 1) - raw;
            new_dir = 1'b0;
        end else if (raw < 17'sd0) begin
            res     = -raw;
            new_dir = 1'b1;
        end else begin
            res     = raw;
            new_dir = dir;
        end
        return {new_dir, res[15:0]};
    endfunction

`ifdef BALL_WRAP_EN
    // Toroidal x: direction is preserved, so no bounce is ever reported.
    function automatic logic [16:0] wrap_axis(
        input logic signed [15:0] pos,
        input logic               dir,
        input logic signed [16:0] max_v
    );
        logic signed [16:0] pos_x;
        logic signed [16:0] raw;
        logic signed [16:0] res;
        pos_x = {pos[15], pos};
        raw   = dir ? (pos_x + SPEED_S) : (pos_x - SPEED_S);
        if (raw > max_v) begin
            res = raw - (max_v + 17'sd1);
        end else if (raw < 17'sd0) begin
            res = raw + (max_v + 17'sd1);
        end else begin
            res = raw;
        end
        return {dir, res[15:0]};
    endfunction
`endif

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic signed [15:0] x1_q, x1_d;
    logic signed [15:0] y1_q, y1_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic               pos_update_q, pos_update_d;
    logic               bounce_q, bounce_d;
    logic [16:0]        step_x;
    logic [16:0]        step_y;

    always_comb begin
`ifdef BALL_WRAP_EN
        step_x = wrap_axis(x1_q, dir_x_q, X_MAX_S);
`else
        step_x = reflect_axis(x1_q, dir_x_q, X_MAX_S);
`endif
        step_y = reflect_axis(y1_q, dir_y_q, Y_MAX_S);
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        pos_update_d = 1'b0;
        bounce_d     = 1'b0;

        // Launch wins over everything, including a coincident frame pulse.
        if (bus.launch) begin
            x1_d    = X_INIT_S;
            y1_d    = Y_INIT_S;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
            div_d   = '0;
            state_d = bus.run ? ST_MOVING : ST_PAUSED;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_MOVING: begin
                    if (!bus.run) begin
                        state_d = ST_PAUSED;
                    end else if (bus.frame_pulse) begin
                        if (div_q == DIV_LAST) begin
                            div_d        = '0;
                            x1_d         = step_x[15:0];
                            y1_d         = step_y[15:0];
                            dir_x_d      = step_x[16];
                            dir_y_d      = step_y[16];
                            pos_update_d = 1'b1;
                            bounce_d     = (step_x[16] != dir_x_q) ||
                                           (step_y[16] != dir_y_q);
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (bus.run) begin
                        state_d = ST_MOVING;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            x1_q         <= X_INIT_S;
            y1_q         <= Y_INIT_S;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            pos_update_q <= 1'b0;
            bounce_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            pos_update_q <= pos_update_d;
            bounce_q     <= bounce_d;
        end
    end

    assign bus.x1         = x1_q;
    assign bus.y1         = y1_q;
    assign bus.dir_x      = dir_x_q;
    assign bus.dir_y      = dir_y_q;
    assign bus.pos_update = pos_update_q;
    assign bus.bounce     = bounce_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_stepper.sv
// ============================================================================
// Module      : tb_ball_stepper
// Description : Directed self-checking bench for ball_stepper; a default
//               instance plus a corner-start instance with STEP_DIV=1.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ball_stepper;

    logic clock;
    logic rst_n;
    logic fp;
    logic run;
    logic launch;
    int   n_tests;
    int   n_fail;

    ball_stepper_if bus_a ();
    ball_stepper_if bus_b ();

    assign bus_a.frame_pulse = fp;
    assign bus_a.run         = run;
    assign bus_a.launch      = launch;
    assign bus_b.frame_pulse = fp;
    assign bus_b.run         = run;
    assign bus_b.launch      = launch;

    ball_stepper dut_a (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ball_stepper #(
        .X_MAX    (63),
        .Y_MAX    (31),
        .X_INIT   (62),
        .Y_INIT   (30),
        .STEP_DIV (1),
        .SPEED    (1)
    ) dut_b (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled 1 time unit after posedge.
    task automatic pulse();
        @(negedge clock);
        fp = 1'b1;
        @(posedge clock);
        #1;
        fp = 1'b0;
    endtask

    task automatic do_launch();
        @(negedge clock);
        launch = 1'b1;
        @(posedge clock);
        #1;
        launch = 1'b0;
    endtask

    task automatic set_run(input logic v);
        @(negedge clock);
        run = v;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        fp      = 1'b0;
        run     = 1'b0;
        launch  = 1'b0;
        repeat (2) idle_cycle();

        check("rst_x1", 32'(bus_a.x1), 32'd32);
        check("rst_y1", 32'(bus_a.y1), 32'd16);
        check("rst_dirs", {30'd0, bus_a.dir_x, bus_a.dir_y}, 32'd3);
        check("rst_pulses", {30'd0, bus_a.pos_update, bus_a.bounce}, 32'd0);

        @(negedge clock);
        rst_n = 1'b1;

        // IDLE ignores frame pulses.
        for (int i = 0; i < 4; i++) begin
            pulse();
            check("idle_no_upd", {31'd0, bus_a.pos_update}, 32'd0);
        end
        check("idle_x1", 32'(bus_a.x1), 32'd32);

        // Divider: step only on the 4th pulse.
        set_run(1'b1);
        do_launch();
        check("launch_no_upd", {31'd0, bus_a.pos_update}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            pulse();
            check("div_no_upd", {31'd0, bus_a.pos_update}, 32'd0);
        end
        check("div_x1_hold", 32'(bus_a.x1), 32'd32);
        check("div_y1_hold", 32'(bus_a.y1), 32'd16);
        pulse();
        check("div_x1_step", 32'(bus_a.x1), 32'd33);
        check("div_y1_step", 32'(bus_a.y1), 32'd17);
        check("div_upd", {31'd0, bus_a.pos_update}, 32'd1);
        check("div_bounce", {31'd0, bus_a.bounce}, 32'd0);
        idle_cycle();
        check("div_upd_1cyc", {31'd0, bus_a.pos_update}, 32'd0);

        // Wall reflect on y after 16 steps.
        do_launch();
        repeat (60) pulse();
        check("wall_y1_s15", 32'(bus_a.y1), 32'd31);
        check("wall_x1_s15", 32'(bus_a.x1), 32'd47);
        check("wall_bounce_s15", {31'd0, bus_a.bounce}, 32'd0);
        repeat (4) pulse();
        check("wall_x1", 32'(bus_a.x1), 32'd48);
        check("wall_y1", 32'(bus_a.y1), 32'd30);
        check("wall_dir_y", {31'd0, bus_a.dir_y}, 32'd0);
        check("wall_dir_x", {31'd0, bus_a.dir_x}, 32'd1);
        check("wall_bounce", {31'd0, bus_a.bounce}, 32'd1);
        check("wall_upd", {31'd0, bus_a.pos_update}, 32'd1);
        idle_cycle();
        check("wall_bounce_1cyc", {31'd0, bus_a.bounce}, 32'd0);
        repeat (4) pulse();
        check("wall_y1_down", 32'(bus_a.y1), 32'd29);

        // Corner hit on the second instance.
        do_launch();
        pulse();
        check("corner1_x1", 32'(bus_b.x1), 32'd63);
        check("corner1_y1", 32'(bus_b.y1), 32'd31);
        check("corner1_bounce", {31'd0, bus_b.bounce}, 32'd0);
        pulse();
`ifdef BALL_WRAP_EN
        check("corner2_x1", 32'(bus_b.x1), 32'd0);
        check("corner2_dirs", {30'd0, bus_b.dir_x, bus_b.dir_y}, 32'd2);
`else
        check("corner2_x1", 32'(bus_b.x1), 32'd62);
        check("corner2_dirs", {30'd0, bus_b.dir_x, bus_b.dir_y}, 32'd0);
`endif
        check("corner2_y1", 32'(bus_b.y1), 32'd30);
        check("corner2_bounce", {31'd0, bus_b.bounce}, 32'd1);
        idle_cycle();
        check("corner_bounce_1cyc", {31'd0, bus_b.bounce}, 32'd0);

        // Pause holds position and divider.
        do_launch();
        repeat (2) pulse();
        set_run(1'b0);
        for (int i = 0; i < 10; i++) begin
            pulse();
            check("pause_no_upd", {31'd0, bus_a.pos_update}, 32'd0);
        end
        check("pause_x1", 32'(bus_a.x1), 32'd32);
        set_run(1'b1);
        pulse();
        check("resume1_upd", {31'd0, bus_a.pos_update}, 32'd0);
        check("resume1_x1", 32'(bus_a.x1), 32'd32);
        pulse();
        check("resume2_x1", 32'(bus_a.x1), 32'd33);
        check("resume2_y1", 32'(bus_a.y1), 32'd17);
        check("resume2_upd", {31'd0, bus_a.pos_update}, 32'd1);

        // Launch colliding with a frame pulse at divider=3.
        do_launch();
        repeat (4) pulse();
        repeat (3) pulse();
        @(negedge clock);
        fp     = 1'b1;
        launch = 1'b1;
        @(posedge clock);
        #1;
        fp     = 1'b0;
        launch = 1'b0;
        check("coll_x1", 32'(bus_a.x1), 32'd32);
        check("coll_y1", 32'(bus_a.y1), 32'd16);
        check("coll_dirs", {30'd0, bus_a.dir_x, bus_a.dir_y}, 32'd3);
        check("coll_upd", {31'd0, bus_a.pos_update}, 32'd0);
        repeat (3) pulse();
        check("coll_hold_x1", 32'(bus_a.x1), 32'd32);
        pulse();
        check("coll_step_x1", 32'(bus_a.x1), 32'd33);

        // Asynchronous reset between edges, then IDLE with run still high.
        do_launch();
        repeat (20) pulse();
        check("pre_rst_x1", 32'(bus_a.x1), 32'd37);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_x1", 32'(bus_a.x1), 32'd32);
        check("arst_y1", 32'(bus_a.y1), 32'd16);
        check("arst_dirs", {30'd0, bus_a.dir_x, bus_a.dir_y}, 32'd3);
        @(negedge clock);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse();
            check("arst_idle_upd", {31'd0, bus_a.pos_update}, 32'd0);
        end
        check("arst_idle_x1", 32'(bus_a.x1), 32'd32);
        check("arst_idle_y1", 32'(bus_a.y1), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
